// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_ctrl: MEM-stage dcache initiator with LL/SC link + wdog  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        valid_in,
  input  logic        dREN_in,
  input  logic        dWEN_in,
  input  logic        is_ll,
  input  logic        is_sc,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_in,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  input  logic        ccinv,
  input  logic [31:0] ccinvaddr,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        memwb_flush,
  output logic [31:0] dmemload_out,
  output logic        link_valid,
  output logic        err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;
  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic        req_ren_q, req_ren_d;
  logic        req_wen_q, req_wen_d;
  logic        req_ll_q, req_ll_d;
  logic        req_sc_q, req_sc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_store_q, req_store_d;
  logic [7:0]  count_q, count_d;
  logic        link_valid_q, link_valid_d;
  logic [31:0] link_addr_q, link_addr_d;

  logic op;
  logic sc_fail;
  logic issue;
  logic busy_hit;

  assign op       = valid_in & (dREN_in | dWEN_in);
  assign sc_fail  = is_sc & ~(link_valid_q & (link_addr_q == addr_in));
  assign issue    = (state_q == S_IDLE) & op & ~sc_fail;
  assign busy_hit = (state_q == S_BUSY) & dhit;

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (issue) state_d = S_BUSY;
      S_BUSY: begin
        if (dhit) begin
          state_d = S_IDLE;
        end else if (count_q + 8'd1 == C_TIMEOUT) begin
          state_d = S_ERR;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmemREN      = 1'b0;
    dmemWEN      = 1'b0;
    dmemaddr     = 32'd0;
    dmemstore    = 32'd0;
    mem_stall    = 1'b0;
    memwb_flush  = 1'b0;
    dmemload_out = 32'd0;
    err          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          mem_stall   = 1'b1;
          memwb_flush = 1'b1;
        end
      end
      S_BUSY: begin
        dmemREN   = req_ren_q;
        dmemWEN   = req_wen_q;
        dmemaddr  = req_addr_q;
        dmemstore = req_store_q;
        if (dhit) begin
          if (req_ren_q) begin
            dmemload_out = dmemload;
          end else if (req_sc_q) begin
            dmemload_out = 32'd1;
          end
        end else begin
          mem_stall   = 1'b1;
          memwb_flush = 1'b1;
        end
      end
      S_ERR: begin
        mem_stall   = 1'b1;
        memwb_flush = 1'b1;
        err         = 1'b1;
      end
      default: ;
    endcase
  end

  // Request is latched once at issue and held stable for the dcache.
  always_comb begin
    req_ren_d   = req_ren_q;
    req_wen_d   = req_wen_q;
    req_ll_d    = req_ll_q;
    req_sc_d    = req_sc_q;
    req_addr_d  = req_addr_q;
    req_store_d = req_store_q;
    if (issue) begin
      req_ren_d   = dREN_in;
      req_wen_d   = dWEN_in & ~dREN_in;
      req_ll_d    = is_ll;
      req_sc_d    = is_sc;
      req_addr_d  = addr_in;
      req_store_d = store_in;
    end
  end

  always_comb begin
    count_d = 8'd0;
    if ((state_q == S_BUSY) && !dhit) begin
      count_d = count_q + 8'd1;
    end
  end

  // An ll completing in the same cycle as a matching snoop keeps the new link.
  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (ccinv && (ccinvaddr == link_addr_q)) begin
      link_valid_d = 1'b0;
    end
    if (busy_hit) begin
      if (req_sc_q) begin
        link_valid_d = 1'b0;
      end else if (req_wen_q && (req_addr_q == link_addr_q)) begin
        link_valid_d = 1'b0;
      end
      if (req_ll_q) begin
        link_valid_d = 1'b1;
        link_addr_d  = req_addr_q;
      end
    end
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      req_ren_q    <= 1'b0;
      req_wen_q    <= 1'b0;
      req_ll_q     <= 1'b0;
      req_sc_q     <= 1'b0;
      req_addr_q   <= 32'd0;
      req_store_q  <= 32'd0;
      count_q      <= 8'd0;
      link_valid_q <= 1'b0;
      link_addr_q  <= 32'd0;
    end else begin
      req_ren_q    <= req_ren_d;
      req_wen_q    <= req_wen_d;
      req_ll_q     <= req_ll_d;
      req_sc_q     <= req_sc_d;
      req_addr_q   <= req_addr_d;
      req_store_q  <= req_store_d;
      count_q      <= count_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign link_valid = link_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_access_ctrl: scoreboard bench with random ops and snoops     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_mem_access_ctrl;
  localparam int TO = 4;

  logic CLK = 1'b0;
  logic nRST, valid_in, dREN_in, dWEN_in, is_ll, is_sc, dhit, ccinv;
  logic [31:0] addr_in, store_in, dmemload, ccinvaddr;
  logic dmemREN, dmemWEN, mem_stall, memwb_flush, link_valid, err;
  logic [31:0] dmemaddr, dmemstore, dmemload_out;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .valid_in(valid_in), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
    .is_ll(is_ll), .is_sc(is_sc), .addr_in(addr_in), .store_in(store_in), .dhit(dhit),
    .dmemload(dmemload), .ccinv(ccinv), .ccinvaddr(ccinvaddr), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
    .memwb_flush(memwb_flush), .dmemload_out(dmemload_out), .link_valid(link_valid), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        req;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] result;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int vectors = 0;
  int miscompares = 0;

  // Reference link register, updated once per cycle ahead of the clock edge.
  logic        m_lv, nv;
  logic [31:0] m_la, na;
  logic        cur_ll, cur_sc, cur_wen;
  logic [31:0] cur_addr;
  logic mon_en, resp_en, inv_en, force_any, force_hit;
  logic [31:0] force_addr;
  logic [31:0] cap_addr, cap_store;
  logic cap_ren, cap_wen;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pick_addr();
    return 32'h100 * $urandom_range(1, 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // dcache and snoop responder
  initial begin : responder
    int cnt;
    int tgt;
    bit seen;
    seen = 0; cnt = 0; tgt = 1;
    dhit = 0; dmemload = 0; ccinv = 0; ccinvaddr = 0;
    cap_addr = 0; cap_store = 0; cap_ren = 0; cap_wen = 0;
    forever begin
      @(posedge CLK); #1;
      dhit = 1'b0;
      dmemload = $urandom;
      if (resp_en && !nRST && (dmemREN || dmemWEN)) begin
        if (!seen) begin
          seen = 1; cnt = 1; tgt = $urandom_range(1, TO);
        end else begin
          cnt++;
        end
        if (cnt == tgt) begin
          dhit = 1'b1;
          dmemload = mem_val(dmemaddr);
          cap_addr = dmemaddr; cap_store = dmemstore; cap_ren = dmemREN; cap_wen = dmemWEN;
        end
      end else begin
        seen = 0;
      end
      ccinv = 1'b0;
      ccinvaddr = $urandom;
      if (force_any || (force_hit && dhit)) begin
        ccinv = 1'b1; ccinvaddr = force_addr;
      end else if (inv_en && $urandom_range(0, 5) == 0) begin
        ccinv = 1'b1;
        ccinvaddr = ($urandom_range(0, 1) == 1) ? m_la : pick_addr();
      end
    end
  end

  // Monitor: pops the scoreboard whenever an instruction leaves MEM
  always @(negedge CLK) begin
    if (nRST) begin
      m_lv = 1'b0; m_la = 32'd0;
    end else if (mon_en) begin
      check("link_valid", link_valid, m_lv);
      check("req_exclusive", dmemREN & dmemWEN, 0);
      check("flush_eq_stall", memwb_flush, mem_stall);
      if (!valid_in) check("idle_stall", mem_stall, 0);
      if (valid_in && !mem_stall) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_completion: got dmemload_out %h expected no completion", dmemload_out);
        end else begin
          e_mon = sb.pop_front();
          check("result", dmemload_out, e_mon.result);
          if (e_mon.req) begin
            check("dhit_at_done", dhit, 1);
            check("req_addr", cap_addr, e_mon.addr);
            check("req_wen", cap_wen, e_mon.wen);
            check("req_ren", cap_ren, !e_mon.wen);
            if (e_mon.wen) check("req_store", cap_store, e_mon.store);
          end else begin
            check("sc_fail_no_req", dmemREN | dmemWEN, 0);
          end
        end
      end
      nv = m_lv; na = m_la;
      if (ccinv && ccinvaddr == m_la) nv = 1'b0;
      if (dhit) begin
        if (cur_ll) begin
          nv = 1'b1; na = cur_addr;
        end else if (cur_sc || (cur_wen && cur_addr == m_la)) begin
          nv = 1'b0;
        end
      end
      m_lv = nv; m_la = na;
    end
  end

  // kind: 0 lw, 1 sw, 2 ll, 3 sc
  task automatic do_op(input int kind, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit fail;
    int n;
    @(posedge CLK); #1;
    fail = (kind == 3) && !(m_lv && m_la == a);
    e.req = !fail;
    e.wen = (kind == 1 || kind == 3);
    e.addr = a;
    e.store = d;
    e.result = (kind == 0 || kind == 2) ? mem_val(a) : ((kind == 3 && !fail) ? 32'd1 : 32'd0);
    sb.push_back(e);
    cur_ll = (kind == 2); cur_sc = (kind == 3); cur_wen = e.wen; cur_addr = a;
    valid_in = 1; dREN_in = !e.wen; dWEN_in = e.wen; is_ll = cur_ll; is_sc = cur_sc;
    addr_in = a; store_in = d;
    n = 0;
    do begin
      @(negedge CLK); n++;
    end while (mem_stall && n < 40);
    if (mem_stall) begin
      vectors++; miscompares++;
      $display("FAIL op_timeout: got mem_stall 1 after %0d cycles expected 0", n);
    end
  endtask

  task automatic idle_cycle(input logic inv, input logic [31:0] a);
    force_addr = a; force_any = inv;
    @(posedge CLK); #1;
    valid_in = 0; dREN_in = 0; dWEN_in = 0; is_ll = 0; is_sc = 0;
    #1 force_any = 0;
    @(negedge CLK);
  endtask

  initial begin
    int kind;
    int wen_cycles;
    logic [31:0] a;
    nRST = 1; valid_in = 0; dREN_in = 0; dWEN_in = 0; is_ll = 0; is_sc = 0;
    addr_in = 0; store_in = 0;
    mon_en = 0; resp_en = 1; inv_en = 0; force_any = 0; force_hit = 0; force_addr = 0;
    m_lv = 0; m_la = 0; cur_ll = 0; cur_sc = 0; cur_wen = 0; cur_addr = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_dmemREN", dmemREN, 0);
    check("rst_dmemWEN", dmemWEN, 0);
    check("rst_dmemaddr", dmemaddr, 0);
    check("rst_dmemstore", dmemstore, 0);
    check("rst_mem_stall", mem_stall, 0);
    check("rst_memwb_flush", memwb_flush, 0);
    check("rst_dmemload_out", dmemload_out, 0);
    check("rst_link_valid", link_valid, 0);
    check("rst_err", err, 0);
    nRST = 0;
    mon_en = 1;

    do_op(0, 32'h100, 32'h0);
    do_op(2, 32'h200, 32'h0);
    do_op(3, 32'h200, 32'h5);
    do_op(2, 32'h200, 32'h0);
    idle_cycle(1, 32'h200);
    do_op(3, 32'h200, 32'h5);
    do_op(2, 32'h300, 32'h0);
    force_addr = 32'h300; force_hit = 1;
    do_op(2, 32'h200, 32'h0);
    force_hit = 0;
    do_op(3, 32'h200, 32'h7);

    inv_en = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle(0, 32'h0);
      kind = $urandom_range(0, 3);
      a = (kind == 3 && $urandom_range(0, 1) == 1) ? m_la : pick_addr();
      do_op(kind, a, $urandom);
    end
    idle_cycle(0, 32'h0);
    inv_en = 0;
    idle_cycle(0, 32'h0);
    check("sb_drained", sb.size(), 0);

    // Watchdog: sw with no dhit
    mon_en = 0; resp_en = 0;
    @(posedge CLK); #1;
    valid_in = 1; dWEN_in = 1; addr_in = 32'h400; store_in = 32'hCAFE;
    wen_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (dmemWEN) wen_cycles++;
    end
    check("timeout_wen_cycles", wen_cycles, TO);
    check("err_set", err, 1);
    check("err_dmemWEN", dmemWEN, 0);
    check("err_dmemREN", dmemREN, 0);
    check("err_stall", mem_stall, 1);
    check("err_flush", memwb_flush, 1);
    @(posedge CLK); #3;
    valid_in = 0; dWEN_in = 0;
    #1 check("err_held_stall", mem_stall, 1);
    #1 nRST = 1;
    #1;
    check("err_rst_err", err, 0);
    check("err_rst_stall", mem_stall, 0);
    @(posedge CLK); #1 nRST = 0;

    // Asynchronous reset in the middle of a request
    resp_en = 1; mon_en = 1;
    do_op(2, 32'h100, 32'h0);
    idle_cycle(0, 32'h0);
    check("ll_link_set", link_valid, 1);
    mon_en = 0; resp_en = 0;
    @(posedge CLK); #1;
    valid_in = 1; dREN_in = 1; addr_in = 32'h180;
    @(negedge CLK);
    @(negedge CLK);
    check("busy_ren", dmemREN, 1);
    #2;
    valid_in = 0; dREN_in = 0;
    nRST = 1;
    #1;
    check("arst_dmemREN", dmemREN, 0);
    check("arst_stall", mem_stall, 0);
    check("arst_flush", memwb_flush, 0);
    check("arst_err", err, 0);
    check("arst_link_valid", link_valid, 0);
    @(posedge CLK); #1 nRST = 0;
    @(negedge CLK);
    check("post_rst_idle", dmemREN | dmemWEN | mem_stall, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
